// File: rtl/hex_display_sequencer_if.sv
// Avalon-MM slave bus for the HEX display sequencer.
// readdata is combinational from address (read latency 0).
interface hex_display_sequencer_if;
    logic        chipselect;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect,
        output address,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/hex_display_sequencer.sv
// Owns the six HEX 7-segment displays.
// Holds six digit nibbles, enable/blink masks and scroll control.
// Times blink and scroll off a free-running tick.
// Drives registered active-low segment patterns.
module hex_display_sequencer #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic                    clk,
    input  logic                    reset,
    hex_display_sequencer_if.slave  bus,
    output logic [41:0]             hex_out
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    // Active-low hex decode, bit 0 = segment a.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // Select nibble idx (0..5) of the 24-bit digit register.
    function automatic logic [3:0] nibble_at(input logic [23:0] d, input logic [3:0] idx);
        case (idx)
            4'd0: nibble_at = d[3:0];
            4'd1: nibble_at = d[7:4];
            4'd2: nibble_at = d[11:8];
            4'd3: nibble_at = d[15:12];
            4'd4: nibble_at = d[19:16];
            default: nibble_at = d[23:20];
        endcase
    endfunction

    logic [23:0]   data_reg;
    logic [5:0]    enable_reg;
    logic [5:0]    blink_reg;
    logic          scroll_en;
    logic          scroll_dir;
    logic          blank_all;
    logic [3:0]    rate;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    step_cnt;
    logic [2:0]    offset;
    logic          blink_phase;

    logic          wr;
    logic          ctrl_wr;
    logic          status_clr;
    logic          tick;
    logic [3:0]    eff_rate;
    logic          step_due;
    logic [2:0]    offset_stepped;
    logic [41:0]   hex_next;
    logic          unused_wdata;

    assign wr         = bus.chipselect & ~bus.write_n;
    assign ctrl_wr    = wr & (bus.address == 2'd2);
    assign status_clr = wr & (bus.address == 2'd3) & bus.writedata[0];
    assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
    assign eff_rate   = (rate == 4'd0) ? 4'd1 : rate;
    assign step_due   = scroll_en & tick & (step_cnt == eff_rate - 4'd1);
    assign unused_wdata = ^{bus.writedata[31:24], bus.writedata[15:14], bus.writedata[7:6]};

    // Next offset for one scroll step in the configured direction.
    always_comb begin
        offset_stepped = offset;
        if (scroll_dir) begin
            offset_stepped = (offset == 3'd0) ? 3'd5 : offset - 3'd1;
        end else begin
            offset_stepped = (offset == 3'd5) ? 3'd0 : offset + 3'd1;
        end
    end

    // Software-visible register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg   <= '0;
            enable_reg <= '0;
            blink_reg  <= '0;
            scroll_en  <= 1'b0;
            scroll_dir <= 1'b0;
            blank_all  <= 1'b0;
            rate       <= '0;
        end else if (wr) begin
            case (bus.address)
                2'd0: data_reg <= bus.writedata[23:0];
                2'd1: begin
                    enable_reg <= bus.writedata[5:0];
                    blink_reg  <= bus.writedata[13:8];
                end
                2'd2: begin
                    scroll_en  <= bus.writedata[0];
                    scroll_dir <= bus.writedata[1];
                    blank_all  <= bus.writedata[2];
                    rate       <= bus.writedata[11:8];
                end
                default: ;
            endcase
        end
    end

    // Free-running timebase and blink phase; register writes never disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt    <= '0;
            blink_phase <= 1'b0;
        end else begin
            tick_cnt    <= tick ? '0 : tick_cnt + TW'(1);
            blink_phase <= blink_phase ^ tick;
        end
    end

    // Scroll stepping: a CTRL write suppresses a due step, a STATUS clear overrides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt <= '0;
            offset   <= '0;
        end else begin
            if (ctrl_wr || !scroll_en) begin
                step_cnt <= '0;
            end else if (tick) begin
                step_cnt <= step_due ? 4'd0 : step_cnt + 4'd1;
            end
            if (status_clr) begin
                offset <= 3'd0;
            end else if (step_due && !ctrl_wr) begin
                offset <= offset_stepped;
            end
        end
    end

    // Segment patterns: rotated digits, masks stay on physical positions.
    always_comb begin
        hex_next = '1;
        for (int i = 0; i < 6; i++) begin
            logic [3:0] idx;
            idx = 4'(i) + {1'b0, offset};
            if (idx >= 4'd6) begin
                idx = idx - 4'd6;
            end
            if (blank_all || !enable_reg[i] || (blink_reg[i] && blink_phase)) begin
                hex_next[7*i +: 7] = 7'h7F;
            end else begin
                hex_next[7*i +: 7] = seg7(nibble_at(data_reg, idx));
            end
        end
    end

    // Output register: one cycle behind the register/offset/phase state.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_out <= '1;
        end else begin
            hex_out <= hex_next;
        end
    end

    // Combinational read mux, no side effects.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0: bus.readdata = {8'b0, data_reg};
            2'd1: bus.readdata = {18'b0, blink_reg, 2'b0, enable_reg};
            2'd2: bus.readdata = {20'b0, rate, 5'b0, blank_all, scroll_dir, scroll_en};
            default: bus.readdata = {25'b0, offset, 3'b0, blink_phase};
        endcase
    end

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Self-checking bench for hex_display_sequencer: directed steps followed by
// randomized register traffic, compared against a behavioural model.
module tb_hex_display_sequencer;

    localparam int TICK_DIV = 4;
    localparam logic [41:0] ALL_BLANK = 42'h3FF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [41:0] hex_out;

    hex_display_sequencer_if bus ();

    hex_display_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .hex_out (hex_out)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int unsigned m_data, m_enable, m_blink, m_rate, m_offset, m_step, m_tick;
    bit          m_scroll, m_dir, m_blank, m_phase;
    logic [41:0] m_hex;
    logic [6:0]  seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [41:0] model_hex();
        logic [41:0] h;
        for (int i = 0; i < 6; i++) begin
            int unsigned d;
            d = (m_data >> (4 * ((i + m_offset) % 6))) & 15;
            if (m_blank || !m_enable[i] || (m_blink[i] && m_phase))
                h[7*i +: 7] = 7'h7F;
            else
                h[7*i +: 7] = seg_lut[d];
        end
        return h;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        case (a)
            0: return 32'(m_data);
            1: return 32'((m_blink << 8) | m_enable);
            2: return 32'((m_rate << 8) | (int'(m_blank) << 2) | (int'(m_dir) << 1) | int'(m_scroll));
            default: return 32'((m_offset << 4) | int'(m_phase));
        endcase
    endfunction

    function automatic bit step_due();
        int unsigned eff;
        eff = (m_rate == 0) ? 1 : m_rate;
        return m_scroll && (m_tick == TICK_DIV - 1) && (m_step == eff - 1);
    endfunction

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_edge();
        bit          wr, tick, due;
        int unsigned a, wd;
        wr = bus.chipselect && !bus.write_n;
        a  = bus.address;
        wd = bus.writedata;
        if (reset) begin
            m_data = 0; m_enable = 0; m_blink = 0; m_rate = 0; m_offset = 0;
            m_step = 0; m_tick = 0; m_scroll = 0; m_dir = 0; m_blank = 0; m_phase = 0;
            m_hex = ALL_BLANK;
            return;
        end
        m_hex = model_hex();
        tick = (m_tick == TICK_DIV - 1);
        due  = step_due();
        m_tick  = tick ? 0 : m_tick + 1;
        m_phase = m_phase ^ tick;
        if (wr && a == 2) m_step = 0;
        else if (!m_scroll) m_step = 0;
        else if (tick) m_step = due ? 0 : m_step + 1;
        if (wr && a == 3 && wd[0]) m_offset = 0;
        else if (due && !(wr && a == 2)) m_offset = m_dir ? (m_offset + 5) % 6 : (m_offset + 1) % 6;
        if (wr) begin
            case (a)
                0: m_data = wd & 32'hFF_FFFF;
                1: begin m_enable = wd & 32'h3F; m_blink = (wd >> 8) & 32'h3F; end
                2: begin
                    m_scroll = wd[0]; m_dir = wd[1]; m_blank = wd[2];
                    m_rate = (wd >> 8) & 32'hF;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("hex_out", hex_out, m_hex);
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        bus.address = 2'(a); bus.writedata = d;
        cyc();
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic check_read(input int a);
        bus.address = 2'(a); bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1;
        check($sformatf("read%0d", a), 42'(bus.readdata), 42'(model_read(a)));
        bus.chipselect = 1'b0;
    endtask

    task automatic wait_offset(input int target);
        int n = 0;
        while (m_offset != target && n < 400) begin cyc(); n++; end
        if (m_offset != target) begin
            n_total++;
            $error("FAIL wait_offset observed=timeout expected=%0d", target);
        end
    endtask

    task automatic wait_due();
        int n = 0;
        while (!step_due() && n < 400) begin cyc(); n++; end
        if (!step_due()) begin
            n_total++;
            $error("FAIL wait_due observed=timeout expected=step_due");
        end
    endtask

    initial begin
        logic [31:0] r;
        int unsigned prev_off;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = '0;

        // 1: reset held two cycles, then idle
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        check("rst_hex", hex_out, ALL_BLANK);
        for (int a = 0; a < 3; a++) check_read(a);
        bus.address = 2'd0; #1;
        check("rst_data", 42'(bus.readdata), 42'd0);
        for (int i = 0; i < 20; i++) cyc();
        check("idle_hex", hex_out, ALL_BLANK);

        // 2: data + enables
        do_write(0, 32'h00FE_DCBA);
        do_write(1, 32'h0000_003F);
        cyc();
        check("hex0_A", 42'(hex_out[6:0]), 42'h08);
        check("hex5_F", 42'(hex_out[41:35]), 42'h0E);
        bus.address = 2'd0; #1;
        check("rd_data", 42'(bus.readdata), 42'h00FE_DCBA);

        // 3: blink on position 0, then blank_all
        do_write(1, 32'h0000_013F);
        for (int i = 0; i < 12; i++) cyc();
        check_read(1);
        do_write(2, 32'h0000_0004);
        cyc();
        check("blank_all", hex_out, ALL_BLANK);
        do_write(2, 32'h0);
        do_write(1, 32'h0000_003F);

        // 4: scroll left at rate 2, then right
        do_write(2, 32'h0000_0201);
        wait_offset(1);
        cyc();
        check("hex0_B", 42'(hex_out[6:0]), 42'h03);
        wait_offset(0);
        check_read(3);
        do_write(2, 32'h0000_0203);
        wait_offset(5);
        wait_offset(4);
        check_read(3);

        // 5: collisions on the step-due cycle
        do_write(2, 32'h0000_0201);
        wait_offset(2);
        wait_due();
        do_write(3, 32'h1);
        bus.address = 2'd3; #1;
        check("clr_wins", 42'(bus.readdata[6:4]), 42'd0);
        wait_due();
        prev_off = m_offset;
        do_write(2, 32'h0000_0201);
        bus.address = 2'd3; #1;
        r = bus.readdata;
        check("ctrl_wins", 42'(r[6:4]), 42'(prev_off));

        // 6: reset mid-scroll at offset 3
        wait_offset(3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midrst_hex", hex_out, ALL_BLANK);
        bus.address = 2'd3; #1;
        check("midrst_status", 42'(bus.readdata), 42'd0);
        check_read(2);

        // Randomized register traffic
        for (int i = 0; i < 600; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 99);
            if (sel < 2) begin
                reset = 1'b1; cyc(); reset = 1'b0;
            end else if (sel < 22) begin
                int a;
                logic [31:0] d;
                a = int'($urandom_range(0, 3));
                d = $urandom;
                if (a == 2) begin
                    d[11:8] = 4'($urandom_range(0, 3));
                    d[2] = ($urandom_range(0, 7) == 0);
                    d[0] = ($urandom_range(0, 3) != 0);
                end
                if (a == 3) d[0] = ($urandom_range(0, 7) == 0);
                do_write(a, d);
            end else begin
                cyc();
            end
            if (i % 7 == 0) check_read(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
